sobel_stream_engine: RTL and testbench

Streaming 3x3 Sobel edge engine for the grayscale-to-edge pipeline. It accepts one grayscale pixel per valid cycle in raster order and keeps two internal line buffers, so every interior pixel after the first two rows produces one result. It computes the Sobel magnitude internally and can optionally binarize it with a run-time threshold. It sits directly downstream of the grayscale converter and is parametrised in pixel width and frame size.

---
 rtl/sobel_stream_engine.sv | 169 ++++++++++++++++
 tb/tb_sobel_stream_engine.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sobel_stream_engine.sv
// Streaming 3x3 Sobel edge engine with two line buffers.
// Emits |Gx|+|Gy| (saturated) or a thresholded binary value per interior pixel.
module sobel_stream_engine #(
  parameter int PIXEL_WIDTH = 8,
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480
) (
  input  logic                   clk_i,
  input  logic                   nreset_i,
  input  logic                   start_i,
  input  logic                   bin_en_i,
  input  logic [PIXEL_WIDTH-1:0] threshold_i,
  input  logic                   px_valid_i,
  input  logic [PIXEL_WIDTH-1:0] px_i,
  output logic                   out_valid_o,
  output logic [PIXEL_WIDTH-1:0] out_px_o,
  output logic                   busy_o,
  output logic                   frame_done_o
);

  localparam int PW = PIXEL_WIDTH;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int GW = PW + 3;
  localparam int MW = PW + 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_e;

  state_e                  state_q;
  logic [CW-1:0]           col_q;
  logic [RW-1:0]           row_q;
  logic                    bin_q;
  logic [PW-1:0]           thr_q;
  logic [2:0][2:0][PW-1:0] win_q;
  logic [2:0][2:0][PW-1:0] win_d;
  logic [PW-1:0]           lb1_q [IMG_WIDTH];
  logic [PW-1:0]           lb2_q [IMG_WIDTH];
  logic                    out_valid_q;
  logic [PW-1:0]           out_px_q;
  logic                    busy_q;
  logic                    done_q;

  logic                    accept;
  logic                    last_col;
  logic                    last_row;
  logic                    emit;
  logic signed [GW-1:0]    gx;
  logic signed [GW-1:0]    gy;
  logic [GW-1:0]           ax;
  logic [GW-1:0]           ay;
  logic [MW-1:0]           mag;
  logic [PW-1:0]           sat;
  logic [PW-1:0]           res;

  function automatic logic signed [GW-1:0] ext(input logic [PW-1:0] v);
    return $signed({3'b000, v});
  endfunction

  assign accept   = px_valid_i &&
                    (state_q == FILL || state_q == RUN);
  assign last_col = (col_q == CW'(IMG_WIDTH - 1));
  assign last_row = (row_q == RW'(IMG_HEIGHT - 1));
  assign emit     = accept && (row_q >= RW'(2)) &&
                    (col_q >= CW'(2));

  // Shift the window left; the new column comes from the line buffers.
  always_comb begin
    win_d = win_q;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 2; j++) begin
        win_d[i][j] = win_q[i][j+1];
      end
    end
    win_d[0][2] = lb2_q[col_q];
    win_d[1][2] = lb1_q[col_q];
    win_d[2][2] = px_i;
  end

  // Sobel gradients and magnitude of the window being completed.
  always_comb begin
    gx  = (ext(win_d[0][2]) + (ext(win_d[1][2]) <<< 1) +
           ext(win_d[2][2])) -
          (ext(win_d[0][0]) + (ext(win_d[1][0]) <<< 1) +
           ext(win_d[2][0]));
    gy  = (ext(win_d[2][0]) + (ext(win_d[2][1]) <<< 1) +
           ext(win_d[2][2])) -
          (ext(win_d[0][0]) + (ext(win_d[0][1]) <<< 1) +
           ext(win_d[0][2]));
    ax  = gx[GW-1] ? GW'(-gx) : GW'(gx);
    ay  = gy[GW-1] ? GW'(-gy) : GW'(gy);
    mag = MW'(ax) + MW'(ay);
    sat = (|mag[MW-1:PW]) ? '1 : mag[PW-1:0];
    res = bin_q ? ((mag >= MW'(thr_q)) ? '1 : '0) : sat;
  end

  // Line buffers hold rows r-1 and r-2; rows 0-1 refill them before use.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      lb2_q[col_q] <= lb1_q[col_q];
      lb1_q[col_q] <= px_i;
    end
  end

  // Frame FSM, counters, window and registered outputs.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      bin_q       <= 1'b0;
      thr_q       <= '0;
      win_q       <= '0;
      out_valid_q <= 1'b0;
      out_px_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      out_valid_q <= emit;
      out_px_q    <= emit ? res : '0;
      done_q      <= emit && last_row && last_col;
      if (accept) begin
        win_q <= win_d;
        if (last_col) begin
          col_q <= '0;
          row_q <= last_row ? '0 : row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= FILL;
            busy_q  <= 1'b1;
            bin_q   <= bin_en_i;
            thr_q   <= threshold_i;
            col_q   <= '0;
            row_q   <= '0;
          end
        end
        FILL: begin
          if (accept && last_col && row_q == RW'(1)) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (accept && last_col && last_row) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_px_o     = out_px_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;

endmodule

// File: tb/tb_sobel_stream_engine.sv
// Directed bench for sobel_stream_engine: 4x4 frames with known
// answers plus a random 6x5 frame with input gaps against a model.
module tb_sobel_stream_engine;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic       start_a = 0, bin_a = 0, pv_a = 0;
  logic [7:0] thr_a = 0, px_a = 0;
  logic       ov_a, busy_a, done_a;
  logic [7:0] opx_a;

  logic       start_b = 0, pv_b = 0;
  logic [7:0] px_b = 0;
  logic       ov_b, busy_b, done_b;
  logic [7:0] opx_b;

  int checks = 0;
  int fails = 0;

  sobel_stream_engine #(
    .PIXEL_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)
  ) dut_a (
    .clk_i(clk), .nreset_i(nrst), .start_i(start_a),
    .bin_en_i(bin_a), .threshold_i(thr_a),
    .px_valid_i(pv_a), .px_i(px_a),
    .out_valid_o(ov_a), .out_px_o(opx_a),
    .busy_o(busy_a), .frame_done_o(done_a)
  );

  sobel_stream_engine #(
    .PIXEL_WIDTH(8), .IMG_WIDTH(6), .IMG_HEIGHT(5)
  ) dut_b (
    .clk_i(clk), .nreset_i(nrst), .start_i(start_b),
    .bin_en_i(1'b0), .threshold_i(8'd0),
    .px_valid_i(pv_b), .px_i(px_b),
    .out_valid_o(ov_b), .out_px_o(opx_b),
    .busy_o(busy_b), .frame_done_o(done_b)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 4x4 frame whose pixel value depends only on its column.
  task automatic frame4(input logic [7:0] c0, c1, c2, c3,
                        input logic bin, input logic [7:0] thr,
                        input logic [7:0] expv, input bit noise);
    logic [7:0] cv [4];
    bit e, last;
    cv[0] = c0; cv[1] = c1; cv[2] = c2; cv[3] = c3;
    bin_a = bin; thr_a = thr;
    start_a = 1; pv_a = 1; px_a = 8'd200;
    tick();
    start_a = 0;
    chk("busy_after_start", busy_a, 1);
    chk("ov_after_start", ov_a, 0);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        pv_a = 1; px_a = cv[c];
        start_a = (r == 1 && c == 1);
        if (noise) begin
          bin_a = ~bin_a;
          thr_a = 8'($urandom);
        end
        tick();
        start_a = 0;
        e = (r >= 2 && c >= 2);
        last = (r == 3 && c == 3);
        chk($sformatf("ov_r%0dc%0d", r, c), ov_a, e);
        chk($sformatf("px_r%0dc%0d", r, c), opx_a,
            e ? expv : 8'd0);
        chk($sformatf("done_r%0dc%0d", r, c), done_a, last);
        chk($sformatf("busy_r%0dc%0d", r, c), busy_a, !last);
      end
    end
    pv_a = 0; bin_a = bin; thr_a = thr;
  endtask

  int img [5][6];
  int expq [$];
  int gotq [$];
  int done_cnt, done_at;

  task automatic collect_b();
    if (ov_b === 1'b1) gotq.push_back(int'(opx_b));
    if (done_b === 1'b1) begin
      done_cnt++;
      done_at = gotq.size();
    end
  endtask

  function automatic int iabs(input int v);
    return v < 0 ? -v : v;
  endfunction

  initial begin
    int gx, gy, m, gap;
    tick();
    tick();
    chk("rst_ov", ov_a, 0);
    chk("rst_px", opx_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_busy_b", busy_b, 0);
    nrst = 1;
    tick();

    frame4(77, 77, 77, 77, 0, 0, 0, 0);
    frame4(0, 0, 10, 10, 0, 0, 40, 0);
    frame4(0, 0, 10, 10, 1, 40, 255, 1);
    frame4(0, 0, 10, 10, 1, 41, 0, 1);
    frame4(0, 0, 255, 255, 0, 0, 255, 0);

    pv_a = 1; px_a = 8'd99;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("idle_ov%0d", k), ov_a, 0);
      chk($sformatf("idle_busy%0d", k), busy_a, 0);
    end
    pv_a = 0;

    start_a = 1; bin_a = 0;
    tick();
    start_a = 0;
    for (int k = 0; k < 7; k++) begin
      pv_a = 1; px_a = 8'(k * 30);
      tick();
    end
    pv_a = 0;
    chk("pre_abort_busy", busy_a, 1);
    nrst = 0;
    #1;
    chk("abort_busy", busy_a, 0);
    chk("abort_ov", ov_a, 0);
    tick();
    nrst = 1;
    pv_a = 1; px_a = 8'd50;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("post_abort_ov%0d", k), ov_a, 0);
      chk($sformatf("post_abort_busy%0d", k), busy_a, 0);
    end
    pv_a = 0;
    frame4(0, 0, 10, 10, 0, 0, 40, 0);

    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 6; c++)
        img[r][c] = int'($urandom_range(0, 255));
    for (int r = 2; r < 5; r++) begin
      for (int c = 2; c < 6; c++) begin
        gx = img[r-2][c] + 2 * img[r-1][c] + img[r][c]
           - img[r-2][c-2] - 2 * img[r-1][c-2] - img[r][c-2];
        gy = img[r][c-2] + 2 * img[r][c-1] + img[r][c]
           - img[r-2][c-2] - 2 * img[r-2][c-1] - img[r-2][c];
        m = iabs(gx) + iabs(gy);
        expq.push_back(m > 255 ? 255 : m);
      end
    end
    done_cnt = 0; done_at = -1;
    start_b = 1;
    tick();
    start_b = 0;
    collect_b();
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 6; c++) begin
        gap = int'($urandom_range(0, 5));
        pv_b = 0;
        for (int g = 0; g < gap; g++) begin
          tick();
          collect_b();
        end
        pv_b = 1; px_b = 8'(img[r][c]);
        tick();
        collect_b();
      end
    end
    pv_b = 0;
    chk("b_busy_end", busy_b, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      collect_b();
    end
    chk("b_count", gotq.size(), 12);
    chk("b_done_cnt", done_cnt, 1);
    chk("b_done_at", done_at, 12);
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("b_res%0d", k),
          k < gotq.size() ? gotq[k] : -1, expq[k]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
